// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bundle for the registered immediate generator.
// Carries the upstream (instruction/format/tag) channel and the downstream
// (immediate/tag/illegal) channel. The slave modport is the generator's view;
// the master modport is the view of whatever drives it and consumes results.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);

    // Upstream channel
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [2:0]        immsrc;
    logic [TAG_W-1:0]  in_tag;

    // Downstream channel
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   immext;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport slave (
        input  in_valid,
        output in_ready,
        input  instr,
        input  immsrc,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output immext,
        output out_tag,
        output out_illegal
    );

    modport master (
        output in_valid,
        input  in_ready,
        output instr,
        output immsrc,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  immext,
        input  out_tag,
        input  out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, XLEN-generic immediate generator with a 1-entry
// skid buffer between decode and execute.
//
// The immediate is formed when an item is accepted, so the output register
// and the skid register both hold finished results (immediate, tag, illegal
// flag). in_ready depends only on the skid valid bit, which keeps out_ready
// off any combinational path back to the upstream stage.
//
// Optional feature macro: IMM_ZICSR_EN
//   defined     : immsrc 101 yields the CSR zimm, zero-extended instr[19:15]
//   not defined : immsrc 101 is reported as an illegal format
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    // Format select encodings
    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_U     = 3'b011;
    localparam logic [2:0] FMT_J     = 3'b100;
    localparam logic [2:0] FMT_ZIMM  = 3'b101;
    localparam logic [2:0] FMT_SHAMT = 3'b110;

    // One buffered result: everything the downstream stage sees for an item
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } item_t;

    // Build the 32-bit signed form first; every format fits in 32 bits, and
    // the final signed size cast replicates bit 31 up to XLEN. Zero-extended
    // formats keep bit 31 clear so the same cast extends them with zeros.
    function automatic item_t build_item(
        input logic [31:0]      ins,
        input logic [2:0]       src,
        input logic [TAG_W-1:0] tag
    );
        item_t             it;
        logic signed [31:0] s32;
        logic               ill;
        ill = 1'b0;
        case (src)
            FMT_I:     s32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:     s32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:     s32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                              ins[11:8], 1'b0};
            FMT_U:     s32 = {ins[31:12], 12'b0};
            FMT_J:     s32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                              ins[30:21], 1'b0};
            FMT_SHAMT: begin
                if (XLEN == 64) begin
                    s32 = {26'b0, ins[25:20]};
                end else begin
                    s32 = {27'b0, ins[24:20]};
                end
            end
`ifdef IMM_ZICSR_EN
            FMT_ZIMM:  s32 = {27'b0, ins[19:15]};
`endif
            default: begin
                s32 = '0;
                ill = 1'b1;
            end
        endcase
        it.imm = XLEN'(s32);
        it.tag = tag;
        it.ill = ill;
        return it;
    endfunction

    item_t or_q, or_d;
    item_t sk_q, sk_d;
    logic  out_vld_q, out_vld_d;
    logic  sk_vld_q, sk_vld_d;

    item_t new_item;
    logic  accept;
    logic  drain;

    // Form the candidate result and the two handshake events for this cycle
    always_comb begin
        new_item = build_item(bus.instr, bus.immsrc, bus.in_tag);
        accept   = bus.in_valid & ~sk_vld_q;
        drain    = out_vld_q & bus.out_ready;
    end

    // Next-state of output and skid registers; flush beats drain and accept,
    // and the skid always refills the output first so order is preserved
    always_comb begin
        or_d      = or_q;
        sk_d      = sk_q;
        out_vld_d = out_vld_q;
        sk_vld_d  = sk_vld_q;
        if (flush) begin
            out_vld_d = 1'b0;
            sk_vld_d  = 1'b0;
        end else if (drain && sk_vld_q) begin
            or_d      = sk_q;
            out_vld_d = 1'b1;
            if (accept) begin
                sk_d = new_item;
            end else begin
                sk_vld_d = 1'b0;
            end
        end else if (!out_vld_q || drain) begin
            if (accept) begin
                or_d      = new_item;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            sk_d     = new_item;
            sk_vld_d = 1'b1;
        end
    end

    // Register update; reset also clears the result so outputs read as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            or_q      <= '0;
            sk_q      <= '0;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
        end else begin
            or_q      <= or_d;
            sk_q      <= sk_d;
            out_vld_q <= out_vld_d;
            sk_vld_q  <= sk_vld_d;
        end
    end

    assign bus.in_ready    = ~sk_vld_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.immext      = or_q.imm;
    assign bus.out_tag     = or_q.tag;
    assign bus.out_illegal = or_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe at XLEN=32, TAG_W=32.
module tb_imm_gen_pipe;

    localparam int XLEN  = 32;
    localparam int TAG_W = 32;

    logic clk;
    logic reset;
    logic flush;

    int checks;
    int errors;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag);
        bus.in_valid = v;
        bus.instr    = ins;
        bus.immsrc   = src;
        bus.in_tag   = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        #3;
        chk("rst_in_ready",  {63'b0, bus.in_ready},    64'd1);
        chk("rst_out_valid", {63'b0, bus.out_valid},   64'd0);
        chk("rst_immext",    {32'b0, bus.immext},      64'd0);
        chk("rst_out_tag",   {32'b0, bus.out_tag},     64'd0);
        chk("rst_illegal",   {63'b0, bus.out_illegal}, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Basic formats at full throughput
        bus.out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'b000, 32'h11);
        tick();
        chk("i_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("i_imm",   {32'b0, bus.immext},    64'hFFFFFFFF);
        chk("i_tag",   {32'b0, bus.out_tag},   64'h11);
        chk("i_ill",   {63'b0, bus.out_illegal}, 64'd0);
        drive(1'b1, 32'hFE20AE23, 3'b001, 32'h22);
        tick();
        chk("s_imm", {32'b0, bus.immext},  64'hFFFFFFFC);
        chk("s_tag", {32'b0, bus.out_tag}, 64'h22);
        drive(1'b1, 32'hFE000CE3, 3'b010, 32'h33);
        tick();
        chk("b_imm", {32'b0, bus.immext}, 64'hFFFFFFF8);
        drive(1'b1, 32'h123450B7, 3'b011, 32'h44);
        tick();
        chk("u_imm", {32'b0, bus.immext}, 64'h12345000);
        drive(1'b1, 32'h0080006F, 3'b100, 32'h55);
        tick();
        chk("j_imm", {32'b0, bus.immext}, 64'h00000008);
        drive(1'b1, 32'h03F00013, 3'b110, 32'h66);
        tick();
        chk("shamt_imm", {32'b0, bus.immext},      64'h1F);
        chk("shamt_ill", {63'b0, bus.out_illegal}, 64'd0);

        // Illegal and optional CSR zimm formats
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 32'h77);
        tick();
        chk("ill7_imm", {32'b0, bus.immext},      64'd0);
        chk("ill7_ill", {63'b0, bus.out_illegal}, 64'd1);
        drive(1'b1, 32'h000F8073, 3'b101, 32'h88);
        tick();
`ifdef IMM_ZICSR_EN
        chk("zimm_imm", {32'b0, bus.immext},      64'h1F);
        chk("zimm_ill", {63'b0, bus.out_illegal}, 64'd0);
`else
        chk("zimm_imm", {32'b0, bus.immext},      64'd0);
        chk("zimm_ill", {63'b0, bus.out_illegal}, 64'd1);
`endif
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk("idle_valid", {63'b0, bus.out_valid}, 64'd0);

        // Stall: A in output, B in skid, C held off
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100013, 3'b000, 32'hA);
        tick();
        chk("stA_tag",   {32'b0, bus.out_tag},  64'hA);
        chk("stA_ready", {63'b0, bus.in_ready}, 64'd1);
        drive(1'b1, 32'h00200013, 3'b000, 32'hB);
        tick();
        chk("stB_tag",   {32'b0, bus.out_tag},  64'hA);
        chk("stB_ready", {63'b0, bus.in_ready}, 64'd0);
        drive(1'b1, 32'h00300013, 3'b000, 32'hC);
        tick();
        chk("stC_tag",   {32'b0, bus.out_tag},  64'hA);
        chk("stC_imm",   {32'b0, bus.immext},   64'd1);
        chk("stC_ready", {63'b0, bus.in_ready}, 64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("drB_tag",   {32'b0, bus.out_tag},   64'hB);
        chk("drB_imm",   {32'b0, bus.immext},    64'd2);
        chk("drB_ready", {63'b0, bus.in_ready},  64'd1);
        tick();
        chk("drC_tag",   {32'b0, bus.out_tag},   64'hC);
        chk("drC_imm",   {32'b0, bus.immext},    64'd3);
        chk("drC_valid", {63'b0, bus.out_valid}, 64'd1);
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        tick();
        chk("drE_valid", {63'b0, bus.out_valid}, 64'd0);

        // Flush with both registers full and an item presented
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100013, 3'b000, 32'hD1);
        tick();
        drive(1'b1, 32'h00200013, 3'b000, 32'hD2);
        tick();
        chk("fl_pre_ready", {63'b0, bus.in_ready}, 64'd0);
        drive(1'b1, 32'h00300013, 3'b000, 32'hD3);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        chk("fl_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("fl_ready", {63'b0, bus.in_ready},  64'd1);
        tick();
        chk("fl_after_valid", {63'b0, bus.out_valid}, 64'd0);

        // Asynchronous reset in the middle of a stall
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'b000, 32'hE1);
        tick();
        drive(1'b1, 32'h00200013, 3'b000, 32'hE2);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", {63'b0, bus.out_valid},   64'd0);
        chk("ar_ready", {63'b0, bus.in_ready},    64'd1);
        chk("ar_imm",   {32'b0, bus.immext},      64'd0);
        chk("ar_tag",   {32'b0, bus.out_tag},     64'd0);
        chk("ar_ill",   {63'b0, bus.out_illegal}, 64'd0);
        #2;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h123450B7, 3'b011, 32'hF1);
        tick();
        chk("post_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("post_imm",   {32'b0, bus.immext},    64'h12345000);
        chk("post_tag",   {32'b0, bus.out_tag},   64'hF1);
        drive(1'b0, 32'h0, 3'b000, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
